// File: rtl/dot_update_scheduler.sv
// dot_update_scheduler: queues processor dot moves and replays them as
// atomic X-then-Y register writes inside the window that follows screenEnd.
// Ports: clk, reset (async, active low), screenEnd, req_valid/req_ready with
//   req_id/req_x/req_y, dotWren/is_Yloc/dotID/dotLoc to the dot registers,
//   backlog, window_done, err_bad_id.
// Build option DOT_SCHED_CHAMPION_EN adds champ_valid/champ_x/champ_y.
module dot_update_scheduler #(
  parameter int NUM_DOTS      = 38,
  parameter int FIFO_DEPTH    = 8,
  parameter int WINDOW_CYCLES = 1024,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          screenEnd,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_id,
  input  logic [9:0]                    req_x,
  input  logic [8:0]                    req_y,
`ifdef DOT_SCHED_CHAMPION_EN
  input  logic                          champ_valid,
  input  logic [9:0]                    champ_x,
  input  logic [8:0]                    champ_y,
`endif
  output logic                          dotWren,
  output logic                          is_Yloc,
  output logic [31:0]                   dotID,
  output logic [31:0]                   dotLoc,
  output logic [$clog2(FIFO_DEPTH):0]   backlog,
  output logic                          window_done,
  output logic                          err_bad_id
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(WINDOW_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_X = 2'd1,
    WR_Y = 2'd2
  } state_t;

  state_t state;
  state_t next;

  logic [31:0]   fifo_id [FIFO_DEPTH];
  logic [9:0]    fifo_x  [FIFO_DEPTH];
  logic [8:0]    fifo_y  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic full;
  logic empty;
  logic accept;
  logic id_ok;
  logic push;
  logic pop;

  logic [9:0] clamp_x;
  logic [8:0] clamp_y;

  logic [WW-1:0] win_cnt;
  logic          win_ok;

  logic        src_champ;
  logic        have_work;
  logic        take;
  logic [31:0] head_id;
  logic [9:0]  head_x;
  logic [8:0]  head_y;

  logic [31:0] cur_id;
  logic [9:0]  cur_x;
  logic [8:0]  cur_y;

  // ---------------- request side ----------------

  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign empty     = count == '0;
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign id_ok     = req_id < 32'(NUM_DOTS);
  // Out-of-range ids complete the handshake but never occupy a slot.
  assign push      = accept && id_ok;
  assign backlog   = count;

  assign clamp_x = (req_x > 10'(X_MAX)) ? 10'(X_MAX) : req_x;
  assign clamp_y = (req_y > 9'(Y_MAX))  ? 9'(Y_MAX)  : req_y;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr] <= req_id;
      fifo_x[wr_ptr]  <= clamp_x;
      fifo_y[wr_ptr]  <= clamp_y;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_bad_id <= 1'b0;
    end else if (accept && !id_ok) begin
      err_bad_id <= 1'b1;
    end
  end

  // ---------------- write window ----------------

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt     <= '0;
      window_done <= 1'b0;
    end else begin
      // A reload on the last open cycle keeps the window open: no pulse.
      window_done <= !screenEnd && (win_cnt == WW'(1));
      if (screenEnd) begin
        win_cnt <= WW'(WINDOW_CYCLES);
      end else if (win_cnt != '0) begin
        win_cnt <= win_cnt - 1'b1;
      end
    end
  end

  // Two cycles must remain so the Y half never lands after the window.
  assign win_ok = win_cnt > WW'(1);

  // ---------------- optional champion entry ----------------

`ifdef DOT_SCHED_CHAMPION_EN
  logic       champ_pend;
  logic [9:0] champ_xq;
  logic [8:0] champ_yq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      champ_pend <= 1'b0;
      champ_xq   <= '0;
      champ_yq   <= '0;
    end else if (champ_valid) begin
      // A fresh write wins over a same-cycle issue of the old value.
      champ_pend <= 1'b1;
      champ_xq   <= (champ_x > 10'(X_MAX)) ? 10'(X_MAX) : champ_x;
      champ_yq   <= (champ_y > 9'(Y_MAX))  ? 9'(Y_MAX)  : champ_y;
    end else if (take && src_champ) begin
      champ_pend <= 1'b0;
    end
  end

  assign src_champ = champ_pend;
  assign head_id   = src_champ ? 32'(NUM_DOTS) : fifo_id[rd_ptr];
  assign head_x    = src_champ ? champ_xq : fifo_x[rd_ptr];
  assign head_y    = src_champ ? champ_yq : fifo_y[rd_ptr];
`else
  assign src_champ = 1'b0;
  assign head_id   = fifo_id[rd_ptr];
  assign head_x    = fifo_x[rd_ptr];
  assign head_y    = fifo_y[rd_ptr];
`endif

  // ---------------- issue FSM ----------------

  assign have_work = src_champ || !empty;
  // A new pair may start from IDLE or straight after a Y write.
  assign take      = win_ok && have_work && (state != WR_X);
  assign pop       = take && !src_champ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = take ? WR_X : IDLE;
      WR_X:    next = WR_Y;
      WR_Y:    next = take ? WR_X : IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_id <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
    end else if (take) begin
      cur_id <= head_id;
      cur_x  <= head_x;
      cur_y  <= head_y;
    end
  end

  always_comb begin
    dotWren = 1'b0;
    is_Yloc = 1'b0;
    unique case (1'b1)
      state == WR_X: dotWren = 1'b1;
      state == WR_Y: begin
        dotWren = 1'b1;
        is_Yloc = 1'b1;
      end
      default: ;
    endcase
  end

  // Outside a pair the last written (Y) location stays on the bus.
  assign dotID  = cur_id;
  assign dotLoc = (state == WR_X) ? {22'd0, cur_x} : {23'd0, cur_y};

endmodule

// File: tb/tb_dot_update_scheduler.sv
// tb_dot_update_scheduler: randomized and directed checks of the
// dot_update_scheduler against a queue-based model of issued pairs.
module tb_dot_update_scheduler;

  localparam int ND = 38;
  localparam int DEPTH = 8;
  localparam int W1 = 40;
  localparam int W2 = 3;

  typedef struct {
    int id;
    int x;
    int y;
  } ent_t;

  typedef struct {
    logic        y;
    logic [31:0] id;
    logic [31:0] loc;
    int          k;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        se, rv, rdy, wren, isy, wdone, bad;
  logic [31:0] rid, did, dloc;
  logic [9:0]  rx;
  logic [8:0]  ry;
  logic [3:0]  blog;

  logic        se2, rv2, rdy2, wren2, isy2, wdone2, bad2;
  logic [31:0] rid2, did2, dloc2;
  logic [9:0]  rx2;
  logic [8:0]  ry2;
  logic [3:0]  blog2;

`ifdef DOT_SCHED_CHAMPION_EN
  logic       cv;
  logic [9:0] cx;
  logic [8:0] cy;
`endif

  int runs = 0;
  int fails = 0;
  ent_t m1[$];
  ent_t m2[$];
  wr_t  obs[$];
  int   wd_cnt;
  int   wd_k;

  dot_update_scheduler #(.WINDOW_CYCLES(W1)) u_dut (
    .clk(clk), .reset(rst_n), .screenEnd(se),
    .req_valid(rv), .req_ready(rdy),
    .req_id(rid), .req_x(rx), .req_y(ry),
`ifdef DOT_SCHED_CHAMPION_EN
    .champ_valid(cv), .champ_x(cx), .champ_y(cy),
`endif
    .dotWren(wren), .is_Yloc(isy), .dotID(did), .dotLoc(dloc),
    .backlog(blog), .window_done(wdone), .err_bad_id(bad)
  );

  dot_update_scheduler #(.WINDOW_CYCLES(W2)) u_short (
    .clk(clk), .reset(rst_n), .screenEnd(se2),
    .req_valid(rv2), .req_ready(rdy2),
    .req_id(rid2), .req_x(rx2), .req_y(ry2),
`ifdef DOT_SCHED_CHAMPION_EN
    .champ_valid(1'b0), .champ_x(10'd0), .champ_y(9'd0),
`endif
    .dotWren(wren2), .is_Yloc(isy2), .dotID(did2), .dotLoc(dloc2),
    .backlog(blog2), .window_done(wdone2), .err_bad_id(bad2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel, input int id, input int x,
                      input int y);
    ent_t e;
    bit acc;
    e.id = id;
    e.x = (x > 639) ? 639 : x;
    e.y = (y > 479) ? 479 : y;
    if (sel == 1) begin
      rv = 1'b1; rid = id; rx = x[9:0]; ry = y[8:0];
      acc = m1.size() < DEPTH;
    end else begin
      rv2 = 1'b1; rid2 = id; rx2 = x[9:0]; ry2 = y[8:0];
      acc = m2.size() < DEPTH;
    end
    step();
    rv = 1'b0;
    rv2 = 1'b0;
    if (acc && id < ND) begin
      if (sel == 1) m1.push_back(e);
      else m2.push_back(e);
    end
  endtask

  task automatic pulse(input int sel);
    if (sel == 1) se = 1'b1;
    else se2 = 1'b1;
    step();
    se = 1'b0;
    se2 = 1'b0;
  endtask

  // k = 0 is the first sample after the edge that captured screenEnd.
  task automatic collect(input int sel, input int n);
    wr_t w;
    obs.delete();
    wd_cnt = 0;
    wd_k = -1;
    for (int k = 0; k < n; k++) begin
      if ((sel == 1) ? wren : wren2) begin
        w.y   = (sel == 1) ? isy : isy2;
        w.id  = (sel == 1) ? did : did2;
        w.loc = (sel == 1) ? dloc : dloc2;
        w.k   = k;
        obs.push_back(w);
      end
      if ((sel == 1) ? wdone : wdone2) begin
        wd_cnt++;
        if (wd_k < 0) wd_k = k;
      end
      step();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    runs++;
    if (wren !== 1'b0) begin
      fails++; $display("FAIL reset_wren got %b exp 0", wren);
    end
    runs++;
    if (blog !== 4'd0) begin
      fails++; $display("FAIL reset_backlog got %0d exp 0", blog);
    end
    runs++;
    if (rdy !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b exp 1", rdy);
    end
    runs++;
    if (bad !== 1'b0 || wdone !== 1'b0) begin
      fails++; $display("FAIL reset_flags got bad=%b wd=%b exp 0", bad, wdone);
    end
    rst_n = 1'b1;
    collect(1, 10);
    runs++;
    if (obs.size() != 0 || wd_cnt != 0) begin
      fails++;
      $display("FAIL reset_quiet got %0d writes %0d done exp 0",
               obs.size(), wd_cnt);
    end
  endtask

  task automatic test_single();
    push(1, 5, 100, 200);
    runs++;
    if (blog !== 4'd1 || bad !== 1'b0) begin
      fails++;
      $display("FAIL single_push got blog=%0d bad=%b exp 1/0", blog, bad);
    end
    collect(1, 4);
    runs++;
    if (obs.size() != 0) begin
      fails++; $display("FAIL single_closed got %0d writes exp 0", obs.size());
    end
    pulse(1);
    collect(1, W1 + 3);
    runs++;
    if (obs.size() != 2) begin
      fails++; $display("FAIL single_count got %0d exp 2", obs.size());
    end else begin
      runs++;
      if (obs[0].k != 1 || obs[0].y !== 1'b0 || obs[0].id !== 32'd5 ||
          obs[0].loc !== 32'd100) begin
        fails++;
        $display("FAIL single_x got k=%0d y=%b id=%0d loc=%0d exp 1/0/5/100",
                 obs[0].k, obs[0].y, obs[0].id, obs[0].loc);
      end
      runs++;
      if (obs[1].k != 2 || obs[1].y !== 1'b1 || obs[1].id !== 32'd5 ||
          obs[1].loc !== 32'd200) begin
        fails++;
        $display("FAIL single_y got k=%0d y=%b id=%0d loc=%0d exp 2/1/5/200",
                 obs[1].k, obs[1].y, obs[1].id, obs[1].loc);
      end
    end
    runs++;
    if (wd_cnt != 1 || wd_k != W1) begin
      fails++;
      $display("FAIL single_done got %0d at %0d exp 1 at %0d",
               wd_cnt, wd_k, W1);
    end
    runs++;
    if (blog !== 4'd0 || did !== 32'd5 || dloc !== 32'd200) begin
      fails++;
      $display("FAIL single_hold got blog=%0d id=%0d loc=%0d exp 0/5/200",
               blog, did, dloc);
    end
    m1.delete();
  endtask

  task automatic test_clamp();
    push(1, 38, 10, 10);
    push(1, 3, 700, 500);
    runs++;
    if (bad !== 1'b1 || blog !== 4'd1) begin
      fails++;
      $display("FAIL clamp_badid got bad=%b blog=%0d exp 1/1", bad, blog);
    end
    pulse(1);
    collect(1, W1 + 3);
    runs++;
    if (obs.size() != 2) begin
      fails++; $display("FAIL clamp_count got %0d exp 2", obs.size());
    end else begin
      runs++;
      if (obs[0].loc !== 32'd639 || obs[1].loc !== 32'd479 ||
          obs[0].id !== 32'd3 || obs[1].id !== 32'd3) begin
        fails++;
        $display("FAIL clamp_loc got %0d/%0d id %0d exp 639/479 id 3",
                 obs[0].loc, obs[1].loc, obs[0].id);
      end
    end
    m1.delete();
  endtask

  task automatic test_full();
    ent_t e;
    for (int i = 0; i < DEPTH; i++) begin
      push(1, i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
    end
    runs++;
    if (blog !== 4'd8 || rdy !== 1'b0) begin
      fails++;
      $display("FAIL full_state got blog=%0d rdy=%b exp 8/0", blog, rdy);
    end
    push(1, 9, 1, 1);
    runs++;
    if (blog !== 4'd8) begin
      fails++; $display("FAIL full_ninth got blog=%0d exp 8", blog);
    end
    pulse(1);
    collect(1, W1 + 3);
    runs++;
    if (obs.size() != 2 * m1.size()) begin
      fails++;
      $display("FAIL full_count got %0d exp %0d", obs.size(), 2 * m1.size());
    end else begin
      for (int i = 0; i < obs.size(); i++) begin
        e = m1[i / 2];
        runs++;
        if (obs[i].k != 1 + i || obs[i].y !== 1'(i % 2) ||
            obs[i].id !== 32'(e.id) ||
            obs[i].loc !== 32'((i % 2) ? e.y : e.x)) begin
          fails++;
          $display("FAIL full_wr%0d got k=%0d y=%b id=%0d loc=%0d exp id=%0d",
                   i, obs[i].k, obs[i].y, obs[i].id, obs[i].loc, e.id);
        end
      end
    end
    m1.delete();
  endtask

  task automatic test_short_window();
    for (int i = 0; i < 4; i++) push(2, 10 + i, 100 + i, 50 + i);
    runs++;
    if (blog2 !== 4'd4) begin
      fails++; $display("FAIL short_fill got %0d exp 4", blog2);
    end
    pulse(2);
    collect(2, 6);
    runs++;
    if (obs.size() != 2 || wd_cnt != 1 || wd_k != W2 || blog2 !== 4'd3) begin
      fails++;
      $display("FAIL short_one got %0d wr %0d done@%0d blog=%0d exp 2/1@3/3",
               obs.size(), wd_cnt, wd_k, blog2);
    end else begin
      runs++;
      if (obs[0].id !== 32'd10 || obs[0].k != 1 || obs[1].loc !== 32'd50) begin
        fails++;
        $display("FAIL short_pair got id=%0d k=%0d yloc=%0d exp 10/1/50",
                 obs[0].id, obs[0].k, obs[1].loc);
      end
    end
    void'(m2.pop_front());
    pulse(2);
    collect(2, 6);
    runs++;
    if (obs.size() != 2 || blog2 !== 4'd2) begin
      fails++;
      $display("FAIL short_resume got %0d wr blog=%0d exp 2/2",
               obs.size(), blog2);
    end else begin
      runs++;
      if (obs[0].id !== 32'(m2[0].id) || obs[0].loc !== 32'(m2[0].x)) begin
        fails++;
        $display("FAIL short_next got id=%0d loc=%0d exp %0d/%0d",
                 obs[0].id, obs[0].loc, m2[0].id, m2[0].x);
      end
    end
  endtask

  task automatic test_reload();
    push(1, 7, 11, 12);
    push(1, 8, 13, 14);
    pulse(1);
    collect(1, 5);
    runs++;
    if (obs.size() != 4 || wd_cnt != 0) begin
      fails++;
      $display("FAIL reload_first got %0d wr %0d done exp 4/0",
               obs.size(), wd_cnt);
    end
    pulse(1);
    collect(1, W1 + 3);
    runs++;
    if (obs.size() != 0 || wd_cnt != 1 || wd_k != W1) begin
      fails++;
      $display("FAIL reload_done got %0d wr %0d done@%0d exp 0/1@%0d",
               obs.size(), wd_cnt, wd_k, W1);
    end
    m1.delete();
  endtask

`ifdef DOT_SCHED_CHAMPION_EN
  task automatic test_champion();
    push(1, 1, 7, 8);
    cv = 1'b1; cx = 10'd320; cy = 9'd50;
    step();
    cv = 1'b0;
    pulse(1);
    collect(1, W1 + 3);
    runs++;
    if (obs.size() != 4) begin
      fails++; $display("FAIL champ_count got %0d exp 4", obs.size());
    end else begin
      runs++;
      if (obs[0].id !== 32'(ND) || obs[0].loc !== 32'd320 ||
          obs[1].loc !== 32'd50 || obs[2].id !== 32'd1 ||
          obs[2].loc !== 32'd7 || obs[3].loc !== 32'd8) begin
        fails++;
        $display("FAIL champ_order got %0d:%0d/%0d then %0d:%0d/%0d",
                 obs[0].id, obs[0].loc, obs[1].loc,
                 obs[2].id, obs[2].loc, obs[3].loc);
      end
    end
    m1.delete();
  endtask
`endif

  task automatic test_random();
    ent_t e;
    int n;
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) begin
        push(1, int'($urandom_range(0, 45)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 511)));
        if ($urandom_range(0, 1) == 1) step();
      end
      runs++;
      if (blog !== 4'(m1.size())) begin
        fails++;
        $display("FAIL rand%0d_blog got %0d exp %0d", r, blog, m1.size());
      end
      pulse(1);
      collect(1, W1 + 3);
      runs++;
      if (obs.size() != 2 * m1.size() || wd_k != W1) begin
        fails++;
        $display("FAIL rand%0d_count got %0d done@%0d exp %0d done@%0d",
                 r, obs.size(), wd_k, 2 * m1.size(), W1);
      end else begin
        for (int i = 0; i < obs.size(); i++) begin
          e = m1[i / 2];
          runs++;
          if (obs[i].k != 1 + i || obs[i].y !== 1'(i % 2) ||
              obs[i].id !== 32'(e.id) ||
              obs[i].loc !== 32'((i % 2) ? e.y : e.x)) begin
            fails++;
            $display("FAIL rand%0d_wr%0d got id=%0d loc=%0d exp %0d/%0d",
                     r, i, obs[i].id, obs[i].loc, e.id,
                     (i % 2) ? e.y : e.x);
          end
        end
      end
      m1.delete();
    end
  endtask

  task automatic test_reset_mid();
    push(1, 2, 5, 6);
    pulse(1);
    step();
    runs++;
    if (wren !== 1'b1) begin
      fails++; $display("FAIL mid_start got %b exp 1", wren);
    end
    rst_n = 1'b0;
    #1;
    runs++;
    if (wren !== 1'b0 || blog !== 4'd0 || bad !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got wren=%b blog=%0d bad=%b exp 0/0/0",
               wren, blog, bad);
    end
    rst_n = 1'b1;
    m1.delete();
    step();
  endtask

  initial begin
    se = 1'b0; rv = 1'b0; rid = '0; rx = '0; ry = '0;
    se2 = 1'b0; rv2 = 1'b0; rid2 = '0; rx2 = '0; ry2 = '0;
`ifdef DOT_SCHED_CHAMPION_EN
    cv = 1'b0; cx = '0; cy = '0;
`endif
    test_reset();
    test_single();
    test_clamp();
    test_full();
    test_short_window();
    test_reload();
`ifdef DOT_SCHED_CHAMPION_EN
    test_champion();
`endif
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
